// File: rtl/seven_segment_capture.sv
// Captures a multiplexed four-digit seven-segment display from its segment/anode pins
// and presents the decoded digits as complete frames with a valid/ack handshake.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
  input  logic       frame_ack,
  output logic [5:0] num0,
  output logic [5:0] num1,
  output logic [5:0] num2,
  output logic [5:0] num3,
  output logic       frame_valid,
  output logic       overrun,
  output logic       pattern_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  localparam logic [7:0] CAPTURE_COUNT = 8'(STABLE_CYCLES - 1);
  localparam logic [5:0] CODE_BLANK    = 6'd16;
  localparam logic [5:0] CODE_DASH     = 6'd17;
  localparam logic [5:0] CODE_BAD      = 6'd63;

  state_t     state;
  logic [6:0] seg_meta, seg_sync, seg_prev;
  logic [3:0] an_meta, an_sync, an_prev;
  logic [7:0] stab_cnt;
  logic [3:0] seen;
  logic [5:0] shadow [4];

  logic       changed;
  logic       selecting;
  logic [1:0] slot;
  logic [3:0] slot_bit;
  logic [5:0] code;
  logic       capture;
  logic [3:0] seen_next;
  logic       frame_done;
  logic [5:0] frame_next [4];

  // Active-low segment patterns, bit6=a ... bit0=g.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 6'd0;
      7'b1001111: decode = 6'd1;
      7'b0010010: decode = 6'd2;
      7'b0000110: decode = 6'd3;
      7'b1001100: decode = 6'd4;
      7'b0100100: decode = 6'd5;
      7'b0100000: decode = 6'd6;
      7'b0001111: decode = 6'd7;
      7'b0000000: decode = 6'd8;
      7'b0000100: decode = 6'd9;
      7'b0001000: decode = 6'd10;
      7'b1100000: decode = 6'd11;
      7'b0110001: decode = 6'd12;
      7'b1000010: decode = 6'd13;
      7'b0110000: decode = 6'd14;
      7'b0111000: decode = 6'd15;
      7'b1111111: decode = CODE_BLANK;
      7'b1111110: decode = CODE_DASH;
      default:    decode = CODE_BAD;
    endcase
  endfunction

  // Two-flop synchronizer, plus one more stage so the stability check compares
  // the synchronized value against itself one clock earlier.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta <= '0;
      seg_sync <= '0;
      seg_prev <= '0;
      an_meta  <= '0;
      an_sync  <= '0;
      an_prev  <= '0;
    end else begin
      seg_meta <= seg_in;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      an_meta  <= an_in;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
    end
  end

  assign changed = {an_sync, seg_sync} != {an_prev, seg_prev};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    selecting = 1'b0;
    slot      = 2'd0;
    case (an_sync)
      4'b0111: begin selecting = 1'b1; slot = 2'd0; end
      4'b1110: begin selecting = 1'b1; slot = 2'd1; end
      4'b1101: begin selecting = 1'b1; slot = 2'd2; end
      4'b1011: begin selecting = 1'b1; slot = 2'd3; end
      default: begin selecting = 1'b0; slot = 2'd0; end
    endcase
  end

  assign slot_bit   = 4'b0001 << slot;
  assign code       = decode(seg_sync);
  assign capture    = (state == SETTLE) && selecting && !changed && (stab_cnt == CAPTURE_COUNT);
  assign seen_next  = seen | slot_bit;
  assign frame_done = capture && (seen_next == 4'hF);

  // The digit being captured on this edge bypasses its (not yet written) shadow.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      frame_next[k] = (slot == 2'(k)) ? code : shadow[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (changed) begin
      stab_cnt <= '0;
    end else if (stab_cnt != 8'hFF) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (selecting) state <= SETTLE;
        end
        SETTLE: begin
          if (!selecting)   state <= IDLE;
          else if (capture) state <= HELD;
        end
        HELD: begin
          if (!selecting)   state <= IDLE;
          else if (changed) state <= SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shadow array is only four entries and must read as blank after reset,
  // so it is reset like ordinary flops rather than left as uninitialized memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) shadow[k] <= CODE_BLANK;
      seen        <= '0;
      num0        <= CODE_BLANK;
      num1        <= CODE_BLANK;
      num2        <= CODE_BLANK;
      num3        <= CODE_BLANK;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      if (frame_valid && frame_ack) frame_valid <= 1'b0;

      if (capture) begin
        shadow[slot] <= code;
        if (code == CODE_BAD) pattern_err <= 1'b1;

        if (frame_done) begin
          seen <= '0;
          // An ack on the completing edge frees the output registers for the new frame.
          if (!frame_valid || frame_ack) begin
            num0        <= frame_next[0];
            num1        <= frame_next[1];
            num2        <= frame_next[2];
            num3        <= frame_next[3];
            frame_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: decode table, frame handshake,
// stability filtering and mid-frame reset.
module tb_seven_segment_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] an_in;
  logic       frame_ack;
  logic [5:0] num0, num1, num2, num3;
  logic       frame_valid, overrun, pattern_err;

  int checks = 0;
  int errors = 0;

  seven_segment_capture #(.STABLE_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_ack   (frame_ack),
    .num0        (num0),
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] seg;
    logic [5:0] code;
  } vec_t;

  vec_t table_v [20];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] slot_an(input int slot);
    case (slot)
      0:       return 4'b0111;
      1:       return 4'b1110;
      2:       return 4'b1101;
      default: return 4'b1011;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the last waited edge.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    an_in  = an;
    seg_in = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input int slot, input logic [6:0] seg);
    drive(slot_an(slot), seg, 22);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    drive_slot(0, s0);
    drive_slot(1, s1);
    drive_slot(2, s2);
    drive_slot(3, s3);
  endtask

  task automatic check_nums(input string tag, input logic [5:0] e0, input logic [5:0] e1,
                            input logic [5:0] e2, input logic [5:0] e3);
    check({tag, "_num0"}, 32'(num0), 32'(e0));
    check({tag, "_num1"}, 32'(num1), 32'(e1));
    check({tag, "_num2"}, 32'(num2), 32'(e2));
    check({tag, "_num3"}, 32'(num3), 32'(e3));
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    an_in     = 4'b1111;
    seg_in    = 7'b1111111;
    frame_ack = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    table_v = '{
      '{7'b0000001, 6'd0},  '{7'b1001111, 6'd1},  '{7'b0010010, 6'd2},  '{7'b0000110, 6'd3},
      '{7'b1001100, 6'd4},  '{7'b0100100, 6'd5},  '{7'b0100000, 6'd6},  '{7'b0001111, 6'd7},
      '{7'b0000000, 6'd8},  '{7'b0000100, 6'd9},  '{7'b0001000, 6'd10}, '{7'b1100000, 6'd11},
      '{7'b0110001, 6'd12}, '{7'b1000010, 6'd13}, '{7'b0110000, 6'd14}, '{7'b0111000, 6'd15},
      '{7'b1111111, 6'd16}, '{7'b1111110, 6'd17}, '{7'b1010101, 6'd63}, '{7'b0000001, 6'd0}
    };

    // Reset state
    do_reset();
    check_nums("reset", 6'd16, 6'd16, 6'd16, 6'd16);
    check("reset_valid", 32'(frame_valid), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_pattern_err", 32'(pattern_err), 0);

    // First frame, 40 clocks per slot; slot-3 capture lands on edge N+18
    drive(slot_an(0), 7'b1001111, 40);
    drive(slot_an(1), 7'b0010010, 40);
    drive(slot_an(2), 7'b0000110, 40);
    an_in  = slot_an(3);
    seg_in = 7'b1001100;
    repeat (18) @(posedge clk);
    #1;
    check("latency_before_edge18", 32'(frame_valid), 0);
    @(posedge clk);
    #1;
    check("latency_at_edge18", 32'(frame_valid), 1);
    drive(slot_an(3), 7'b1001100, 21);
    check_nums("frame1", 6'd1, 6'd2, 6'd3, 6'd4);
    check("frame1_overrun", 32'(overrun), 0);

    ack_pulse();
    check("ack_clears_valid", 32'(frame_valid), 0);

    // Slot 0 only held 10 clocks with a glitch at 5: no capture, mask unchanged
    drive(slot_an(0), 7'b0100100, 5);
    drive(slot_an(0), 7'b0100000, 5);
    drive(4'b1111, 7'b0100000, 5);
    drive_slot(1, 7'b0000000);
    drive_slot(2, 7'b0000100);
    drive_slot(3, 7'b0001000);
    check("glitch_no_frame", 32'(frame_valid), 0);
    drive_slot(0, 7'b1100000);
    check("glitch_frame_valid", 32'(frame_valid), 1);
    check_nums("glitch", 6'd11, 6'd8, 6'd9, 6'd10);

    // Completion with ack on the same edge: loads, stays valid, no overrun
    drive_slot(0, 7'b0110001);
    drive_slot(1, 7'b1000010);
    drive_slot(2, 7'b0110000);
    an_in  = slot_an(3);
    seg_in = 7'b0111000;
    repeat (18) @(posedge clk);
    #1;
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    drive(slot_an(3), 7'b0111000, 3);
    check("ack_on_done_valid", 32'(frame_valid), 1);
    check("ack_on_done_overrun", 32'(overrun), 0);
    check_nums("ack_on_done", 6'd12, 6'd13, 6'd14, 6'd15);

    // Completion without ack: outputs frozen, overrun sticky
    scan4(7'b0001111, 7'b0100000, 7'b0100100, 7'b0000001);
    check("overrun_set", 32'(overrun), 1);
    check("overrun_valid", 32'(frame_valid), 1);
    check_nums("overrun", 6'd12, 6'd13, 6'd14, 6'd15);

    ack_pulse();
    check("ack2_clears_valid", 32'(frame_valid), 0);
    check("pattern_err_before_table", 32'(pattern_err), 0);

    // Decode table, four records per frame in slot order
    for (int f = 0; f < 5; f++) begin
      scan4(table_v[4*f].seg, table_v[4*f+1].seg, table_v[4*f+2].seg, table_v[4*f+3].seg);
      check($sformatf("table%0d_valid", f), 32'(frame_valid), 1);
      check_nums($sformatf("table%0d", f), table_v[4*f].code, table_v[4*f+1].code,
                 table_v[4*f+2].code, table_v[4*f+3].code);
      check($sformatf("table%0d_pattern_err", f), 32'(pattern_err), (f == 4) ? 1 : 0);
      ack_pulse();
    end
    check("overrun_sticky", 32'(overrun), 1);

    // Non-selecting anode values never fill slot 0
    drive(4'b1111, 7'b0000000, 30);
    drive(4'b0011, 7'b0000000, 30);
    drive_slot(1, 7'b1001111);
    drive_slot(2, 7'b1001111);
    drive_slot(3, 7'b1001111);
    check("nonselect_no_frame", 32'(frame_valid), 0);

    // Reset mid-frame discards slots 0 and 1
    do_reset();
    check_nums("reset2", 6'd16, 6'd16, 6'd16, 6'd16);
    check("reset2_overrun", 32'(overrun), 0);
    check("reset2_pattern_err", 32'(pattern_err), 0);
    drive_slot(0, 7'b1001111);
    drive_slot(1, 7'b0010010);
    do_reset();
    drive_slot(2, 7'b0000110);
    check("midreset_after_s2", 32'(frame_valid), 0);
    drive_slot(3, 7'b1001100);
    check("midreset_after_s3", 32'(frame_valid), 0);
    drive_slot(0, 7'b0100100);
    check("midreset_after_s0", 32'(frame_valid), 0);
    drive_slot(1, 7'b0100000);
    check("midreset_after_s1", 32'(frame_valid), 1);
    check_nums("midreset", 6'd5, 6'd6, 6'd3, 6'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive clocks a synchronized {an_in, seg_in} value must hold before capture; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 seg_in  input  7  segment lines, active-low; bit6=a ... bit0=g.
REQ-005 an_in  input  4  anode lines, active-low.
REQ-006 frame_ack  input  1  consumer acknowledge of current frame.
REQ-007 num0..num3  output  6 each  decoded digit codes of last completed frame.
REQ-008 frame_valid  output  1  a completed, unacknowledged frame is on num0..num3.
REQ-009 overrun  output  1  sticky: a frame completed while frame_valid=1.
REQ-010 pattern_err  output  1  sticky: a captured seg_in matched no legal pattern.

Function
REQ-011 seg_in and an_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Digit select SHALL be: an=0111 -> slot0; 1110 -> slot1; 1101 -> slot2; 1011 -> slot3; any other an value is non-selecting.
REQ-013 A stability counter (8 bits) SHALL reset to 0 when the synchronized {an,seg} differs from its value one clock earlier, else increment, saturating at 255.
REQ-014 The FSM SHALL have states IDLE, SETTLE and HELD.
REQ-015 IDLE: an non-selecting; move to SETTLE on the first clock where an is selecting.
REQ-016 SETTLE: move to IDLE if an becomes non-selecting; capture and move to HELD when the counter reaches STABLE_CYCLES-1.
REQ-017 HELD: no further capture; move to SETTLE on any change of {an,seg}, or to IDLE if an becomes non-selecting.
REQ-018 Capture latency: a pin value first present before edge N and held SHALL be captured at edge N+STABLE_CYCLES+2.
REQ-019 The seg_in decode SHALL be active-low:
- 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
- 0000000=8, 0000100=9, 0001000=10, 1100000=11, 0110001=12, 1000010=13, 0110000=14, 0111000=15
- 1111111=16 (blank), 1111110=17 (dash)
- any other pattern -> code 63, and pattern_err set.
REQ-020 On capture, the code SHALL be written into a shadow register for the selected slot, and that slot's bit SHALL be set in a 4-bit seen mask.
REQ-021 Frame complete SHALL occur at the capture that makes the seen mask 1111; on that edge the mask SHALL clear.
REQ-022 On frame complete with frame_valid=0, the shadows SHALL be copied to num0..num3 (the just-captured code included) and frame_valid set the same edge.
REQ-023 frame_ack=1 while frame_valid=1 SHALL clear frame_valid next edge; frame_ack while frame_valid=0 SHALL be ignored.
REQ-024 On frame complete with frame_valid=1 and frame_ack=0: num0..num3 and frame_valid unchanged; overrun set.
REQ-025 On frame complete with frame_valid=1 and frame_ack=1: new frame loaded, frame_valid stays 1, overrun not set.
REQ-026 Recapture of an already-seen slot before frame complete SHALL overwrite that shadow without a mask change.
REQ-027 overrun and pattern_err SHALL clear only on rst.

Reset
REQ-028 rst SHALL asynchronously force:
- FSM to IDLE; counter, synchronizers and seen mask to 0
- shadows and num0..num3 to 16
- frame_valid, overrun and pattern_err to 0
REQ-029 Reset mid-frame SHALL discard partial captures; the first frame after reset needs all four slots recaptured.

Verification
REQ-030 Reset check: assert rst -> num0..3=16, frame_valid=0, overrun=0, pattern_err=0.
REQ-031 Scan slots 0..3 with seg 1001111, 0010010, 0000110, 1001100, each held 40 clocks (STABLE_CYCLES=16) -> num0..3=1,2,3,4; frame_valid rises at the slot-3 capture edge, exactly 18 clocks after that slot's value is applied.
REQ-032 Hold a slot for 10 clocks only, with seg glitches every 5 clocks -> no capture, seen mask unchanged.
REQ-033 Two full frames without frame_ack -> second frame: num unchanged, overrun=1; frame_ack pulse on the second completion edge -> new values loaded, frame_valid stays 1, no overrun.
REQ-034 seg 1010101 on slot2 -> num2=63 after frame completes, pattern_err=1; an=1111 and an=0011 -> FSM stays IDLE, no capture.
REQ-035 rst asserted after slots 0 and 1 captured, then scan slots 2,3,0,1 -> frame_valid rises only after slot 1 is captured.
